// File: rtl/hilo_md_unit.sv
// HI/LO unit for the E stage: single-cycle MULT/MULTU, MTHI/MTLO, MFHI/MFLO read mux,
// and a radix-2 restoring divider that stalls the pipeline while it iterates.
module hilo_md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       alucontrol,
  input  logic             valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] MULT_CONTROL  = 5'b11000;
  localparam logic [4:0] MULTU_CONTROL = 5'b11001;
  localparam logic [4:0] DIV_CONTROL   = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL  = 5'b11011;
  localparam logic [4:0] MTHI_CONTROL  = 5'b11100;
  localparam logic [4:0] MTLO_CONTROL  = 5'b11101;
  localparam logic [4:0] MFHI_CONTROL  = 5'b11110;
  localparam logic [4:0] MFLO_CONTROL  = 5'b11111;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_r, state_nxt_s;
  logic [WIDTH-1:0]   hi_r, lo_r, hi_nxt_s, lo_nxt_s;
  logic [WIDTH-1:0]   dq_r, dvs_r, rem_r;
  logic [CW-1:0]      cnt_r;
  logic               qsign_r, rsign_r, dz_r;
  logic               issue_s, start_div_s, div_signed_s, stall_s;
  logic [2*WIDTH-1:0] sprod_s, uprod_s;
  logic [WIDTH:0]     rem_sh_s, diff_s;
  logic               qbit_s;
  logic [WIDTH-1:0]   rem_step_s;

  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
    neg_f = ~v + ONE_W;
  endfunction

  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v);
    abs_f = v[WIDTH-1] ? neg_f(v) : v;
  endfunction

  assign issue_s      = valid & ~flush & (state_r == S_IDLE);
  assign div_signed_s = (alucontrol == DIV_CONTROL);
  assign sprod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign uprod_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // One restoring-division step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    rem_sh_s   = {rem_r, dq_r[WIDTH-1]};
    diff_s     = rem_sh_s - {1'b0, dvs_r};
    qbit_s     = ~diff_s[WIDTH];
    rem_step_s = qbit_s ? diff_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
  end

  // Next-state, stall and HI/LO write selection.
  always_comb begin
    state_nxt_s = state_r;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    stall_s     = 1'b0;
    start_div_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (issue_s) begin
          case (alucontrol)
            MULT_CONTROL:  {hi_nxt_s, lo_nxt_s} = sprod_s;
            MULTU_CONTROL: {hi_nxt_s, lo_nxt_s} = uprod_s;
            MTHI_CONTROL:  hi_nxt_s = a;
            MTLO_CONTROL:  lo_nxt_s = a;
            DIV_CONTROL, DIVU_CONTROL: begin
              stall_s     = 1'b1;
              start_div_s = 1'b1;
              state_nxt_s = (b == {WIDTH{1'b0}}) ? S_DONE : S_RUN;
            end
            default: state_nxt_s = S_IDLE;
          endcase
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_nxt_s = S_IDLE;
        end else begin
          stall_s     = 1'b1;
          state_nxt_s = (cnt_r == CNT_LAST) ? S_DONE : S_RUN;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
        // A divide by zero reaches DONE without computing anything, so nothing is written.
        if (!flush && !dz_r) begin
          lo_nxt_s = qsign_r ? neg_f(dq_r) : dq_r;
          hi_nxt_s = rsign_r ? neg_f(rem_r) : rem_r;
        end else begin
          lo_nxt_s = lo_r;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM state and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= S_IDLE;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      hi_r    <= hi_nxt_s;
      lo_r    <= lo_nxt_s;
    end
  end

  // Divider datapath: operand capture at issue, then one quotient bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dq_r    <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      qsign_r <= 1'b0;
      rsign_r <= 1'b0;
      dz_r    <= 1'b0;
    end else if (start_div_s) begin
      dq_r    <= div_signed_s ? abs_f(a) : a;
      dvs_r   <= div_signed_s ? abs_f(b) : b;
      rem_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      qsign_r <= div_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
      rsign_r <= div_signed_s & a[WIDTH-1];
      dz_r    <= (b == {WIDTH{1'b0}});
    end else if (state_r == S_RUN && !flush) begin
      dq_r  <= {dq_r[WIDTH-2:0], qbit_s};
      rem_r <= rem_step_s;
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Move-from read mux straight off the current HI/LO.
  always_comb begin
    case (alucontrol)
      MFHI_CONTROL: result = hi_r;
      MFLO_CONTROL: result = lo_r;
      default:      result = {WIDTH{1'b0}};
    endcase
  end

  assign stall = stall_s;
  assign hi    = hi_r;
  assign lo    = lo_r;

endmodule
